key_mode_ctrl: RTL
==================

# key_mode_ctrl

Parametrised run-mode selector for board-level bring-up. Two push-buttons (next/previous) are synchronised, debounced and edge-detected to step a registered mode index through `NUM_MODES` values with wrap-around. A long press on either key returns the index to `RESET_MODE`. The block drives the one-hot mode LEDs and a mode-change strobe to the top-level run-mode mux, for example to select weight configuration or inference test.

## Interface
- `NUM_MODES`, 4: number of modes; must be ≥ 2.
- `RESET_MODE`, 0: mode after reset and after a long press; must be < `NUM_MODES`.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a key level; must be ≥ 1.
- `LONG_PRESS_CYCLES`, 50000000: debounced hold length that triggers a long press; 0 disables long press.
- `KEY_ACTIVE_LOW`, 1: when 1, a key reads pressed at pin level 0.
- `CLK` input 1: clock.
- `RST_N` input 1: reset, asynchronous, active-low.
- `Key_Next` input 1: raw asynchronous button, next mode.
- `Key_Prev` input 1: raw asynchronous button, previous mode.
- `Mode_Lock` input 1: when 1, all key events are discarded and the mode is frozen.
- `Mode_Index` output `MODE_W`: current mode, where `MODE_W = max(1, clog2(NUM_MODES))`.
- `Mode_OneHot` output `NUM_MODES`: LED drive; bit `Mode_Index` is set.
- `Mode_Change` output 1: one-cycle pulse in the cycle `Mode_Index` takes a new value.

## Operation
- **Per key, synchroniser:** a 2-flop synchroniser. Both flops reset to the released pin level, which is 1 when `KEY_ACTIVE_LOW` = 1.
- **Per key, debouncer:**
  - The debounced level resets to released.
  - A counter increments each cycle the synchronised level differs from the debounced level.
  - The counter clears whenever the two levels agree, so a single-cycle glitch restarts the count.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronised value and the counter clears.
- **Per key, press event:** one cycle, on a debounced released→pressed transition.
- **Per key, long event:**
  - A hold counter runs while the debounced level is pressed.
  - The long event is one cycle, when the hold counter reaches `LONG_PRESS_CYCLES`.
  - It fires at most once per hold and re-arms on debounced release.
- **Mode update priority,** evaluated every cycle, first match wins:
  1. `Mode_Lock` = 1: no change. Events in this cycle are dropped, not queued.
  2. Any long event: index becomes `RESET_MODE`.
  3. Next press and prev press in the same cycle: no change.
  4. Next press: index + 1; `NUM_MODES`-1 wraps to 0.
  5. Prev press: index − 1; 0 wraps to `NUM_MODES`-1.
- **`Mode_Change`:** asserted only if the new index differs from the old one. A long press while already in `RESET_MODE` gives no pulse.
- **Short press before long press:** the short press acts at the press edge. A subsequent long press on the same hold overrides it.
- **Reset values:** `Mode_Index` = `RESET_MODE`, `Mode_OneHot` = 1 << `RESET_MODE`, `Mode_Change` = 0, all counters 0.
- **Reset mid-press:** after reset release, a key still held must first debounce to pressed. It generates no press event until released and pressed again.
- **Output registers:** all outputs are registered. `Mode_OneHot` is always consistent with `Mode_Index` in the same cycle.

## Timing
- **Press latency:** the pin changes and is first sampled at cycle 0; the synchronised value is visible at cycle 2.
  - The debounced level changes at cycle 2 + `DEBOUNCE_CYCLES`.
  - The press event is combinational from the debounced edge in that same cycle.
  - `Mode_Index`, `Mode_OneHot` and `Mode_Change` update at cycle 3 + `DEBOUNCE_CYCLES`.
- **Long-press latency:** the long event fires `LONG_PRESS_CYCLES` cycles after the debounced press. The outputs update one cycle later.
- **Release:** debounced with the same rule. Release produces no mode event.
- **Counter widths:** `clog2(DEBOUNCE_CYCLES+1)` and `clog2(LONG_PRESS_CYCLES+1)`. Counters saturate and never wrap.

## Structure
- Shared package/header holds:
  - the `MODE_W` computation;
  - a `CLOG2` helper;
  - the released-level constant derived from `KEY_ACTIVE_LOW`.
- One sub-module, `key_debounce`, instantiated twice. It contains the synchroniser, debounce counter, hold counter and event outputs. Parameters: `DEBOUNCE_CYCLES`, `LONG_PRESS_CYCLES`, `KEY_ACTIVE_LOW`. Outputs: `Key_Level`, `Key_Press`, `Key_Long`.
- The top module holds the priority logic, wrap arithmetic and output registers.

## Test plan
Bench parameters: `NUM_MODES`=3, `RESET_MODE`=0, `DEBOUNCE_CYCLES`=8, `LONG_PRESS_CYCLES`=32, `KEY_ACTIVE_LOW`=1.
- **Basic stepping and wrap:** after reset, `Mode_Index`=0 and `Mode_OneHot`=3'b001. Three clean `Key_Next` presses → index 1, 2, 0. Each update lands at cycle 11 after the pin edge with one `Mode_Change` pulse.
- **Prev wrap:** from 0, one `Key_Prev` press → index 2 and `Mode_OneHot`=3'b100.
- **Glitch rejection:** `Key_Next` low for 7 cycles, high for 1, then low for 8 cycles → exactly one step, taken 8 stable cycles after the glitch ends. A 7-cycle pulse alone → no change.
- **Long press:** from index 1, hold `Key_Next` for 60 cycles → index 2 at the short-press time, then 0 at 32 cycles later. Exactly two `Mode_Change` pulses.
- **Simultaneous and lock:** both keys pressed on the same cycle → no change and no pulse. With `Mode_Lock`=1, a `Key_Next` press → no change. Deasserting lock while the key is still held → still no change.
- **Reset mid-hold:** assert `RST_N`=0 while `Key_Prev` is held, release reset with the key still held → index stays 0. The next fresh press → index 2.

Source files
------------

// File: rtl/key_mode_ctrl_pkg.sv
// key_mode_ctrl_pkg
//   Shared helpers for the run-mode selector:
//     CLOG2          - ceiling log2, evaluated at elaboration time
//     mode_width     - width of the mode index, never below 1
//     released_level - pin level of a key that is not pressed
package key_mode_ctrl_pkg;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int mode_width(input int num_modes);
        return (CLOG2(num_modes) < 1) ? 1 : CLOG2(num_modes);
    endfunction

    function automatic logic released_level(input int key_active_low);
        return (key_active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/key_mode_ctrl_debounce.sv
// key_debounce
//   One push-button front end: 2-flop synchroniser, debounce counter,
//   hold counter and single-cycle press / long-press events.
//   Ports:
//     CLK, RST_N  - clock, asynchronous active-low reset
//     Key_Raw     - raw asynchronous pin
//     Key_Level   - debounced level, 1 = pressed
//     Key_Press   - one cycle on a debounced released->pressed edge
//     Key_Long    - one cycle when a hold reaches LONG_PRESS_CYCLES
module key_debounce
    import key_mode_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int KEY_ACTIVE_LOW    = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic Key_Raw,
    output logic Key_Level,
    output logic Key_Press,
    output logic Key_Long
);

    localparam logic REL  = released_level(KEY_ACTIVE_LOW);
    localparam int   DB_W = (CLOG2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : CLOG2(DEBOUNCE_CYCLES + 1);
    localparam int   HD_W = (CLOG2(LONG_PRESS_CYCLES + 1) < 1) ? 1 : CLOG2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HD_W-1:0] HOLD_MAX = HD_W'(LONG_PRESS_CYCLES);

    logic            sync_p0, sync_p1;
    logic            sync_vld_p0, sync_vld_p1;
    logic            deb_lvl_p2;
    logic [DB_W-1:0] deb_cnt;
    logic            pressed_p2, pressed_p3;
    logic            armed;
    logic [HD_W-1:0] hold_cnt;
    logic            long_fired;

    // Stage p0/p1: synchroniser. The valid bits mark when sync_p1 really
    // reflects the pin rather than the reset value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_p0     <= REL;
            sync_p1     <= REL;
            sync_vld_p0 <= 1'b0;
            sync_vld_p1 <= 1'b0;
        end else begin
            sync_p0     <= Key_Raw;
            sync_p1     <= sync_p0;
            sync_vld_p0 <= 1'b1;
            sync_vld_p1 <= sync_vld_p0;
        end
    end

    // Stage p2: debounce. The counter only advances while the levels disagree,
    // so any agreeing cycle restarts the qualification window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_lvl_p2 <= REL;
            deb_cnt    <= '0;
        end else if (sync_p1 == deb_lvl_p2) begin
            deb_cnt    <= '0;
        end else if (deb_cnt == DB_MAX) begin
            deb_lvl_p2 <= sync_p1;
            deb_cnt    <= '0;
        end else begin
            deb_cnt    <= deb_cnt + DB_W'(1);
        end
    end

    assign pressed_p2 = (deb_lvl_p2 != REL);

    // Stage p3: edge history, arming and hold counting. A key held through
    // reset stays disarmed until it has been seen released, so it cannot
    // produce a press on its first debounce after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pressed_p3 <= 1'b0;
            armed      <= 1'b0;
            hold_cnt   <= '0;
            long_fired <= 1'b0;
        end else begin
            pressed_p3 <= pressed_p2;
            if (sync_vld_p1 && !pressed_p2 && (sync_p1 == REL)) armed <= 1'b1;
            if (!pressed_p2) begin
                hold_cnt   <= '0;
                long_fired <= 1'b0;
            end else begin
                if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HD_W'(1);
                if (Key_Long) long_fired <= 1'b1;
            end
        end
    end

    assign Key_Level = pressed_p2;
    assign Key_Press = armed && pressed_p2 && !pressed_p3;
    assign Key_Long  = (LONG_PRESS_CYCLES != 0) && pressed_p2 &&
                       (hold_cnt == HOLD_MAX) && !long_fired;

endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl
//   Run-mode selector driven by next/previous push-buttons.
//   Ports:
//     CLK, RST_N   - clock, asynchronous active-low reset
//     Key_Next     - raw button, step to next mode
//     Key_Prev     - raw button, step to previous mode
//     Mode_Lock    - freezes the mode and discards key events
//     Mode_Index   - registered current mode
//     Mode_OneHot  - registered LED drive, bit Mode_Index set
//     Mode_Change  - one-cycle pulse when Mode_Index takes a new value
module key_mode_ctrl
    import key_mode_ctrl_pkg::*;
#(
    parameter  int NUM_MODES         = 4,
    parameter  int RESET_MODE        = 0,
    parameter  int DEBOUNCE_CYCLES   = 1000000,
    parameter  int LONG_PRESS_CYCLES = 50000000,
    parameter  int KEY_ACTIVE_LOW    = 1,
    localparam int MODE_W            = mode_width(NUM_MODES)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 Key_Next,
    input  logic                 Key_Prev,
    input  logic                 Mode_Lock,
    output logic [MODE_W-1:0]    Mode_Index,
    output logic [NUM_MODES-1:0] Mode_OneHot,
    output logic                 Mode_Change
);

    localparam logic [MODE_W-1:0]    RESET_IDX  = MODE_W'(RESET_MODE);
    localparam logic [MODE_W-1:0]    LAST_IDX   = MODE_W'(NUM_MODES - 1);
    localparam logic [NUM_MODES-1:0] ONEHOT_ONE = NUM_MODES'(1);

    logic next_level, next_press, next_long;
    logic prev_level, prev_press, prev_long;
    logic unused_levels;
    logic [MODE_W-1:0]    mode_nxt;
    logic [NUM_MODES-1:0] onehot_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .KEY_ACTIVE_LOW    (KEY_ACTIVE_LOW)
    ) u_key_next (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Key_Raw   (Key_Next),
        .Key_Level (next_level),
        .Key_Press (next_press),
        .Key_Long  (next_long)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .KEY_ACTIVE_LOW    (KEY_ACTIVE_LOW)
    ) u_key_prev (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Key_Raw   (Key_Prev),
        .Key_Level (prev_level),
        .Key_Press (prev_press),
        .Key_Long  (prev_long)
    );

    // Debounced levels are available for debug but not used by the mode logic.
    assign unused_levels = next_level ^ prev_level;

    // Priority: lock, long press, simultaneous presses, next, prev.
    always_comb begin
        mode_nxt = Mode_Index;
        if (!Mode_Lock) begin
            if (next_long || prev_long) begin
                mode_nxt = RESET_IDX;
            end else if (next_press && prev_press) begin
                mode_nxt = Mode_Index;
            end else if (next_press) begin
                mode_nxt = (Mode_Index == LAST_IDX) ? '0 : Mode_Index + MODE_W'(1);
            end else if (prev_press) begin
                mode_nxt = (Mode_Index == '0) ? LAST_IDX : Mode_Index - MODE_W'(1);
            end
        end
        onehot_nxt = ONEHOT_ONE << mode_nxt;
    end

    // Output registers: index, LEDs and change strobe update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Mode_Index  <= RESET_IDX;
            Mode_OneHot <= ONEHOT_ONE << RESET_MODE;
            Mode_Change <= 1'b0;
        end else begin
            Mode_Index  <= mode_nxt;
            Mode_OneHot <= onehot_nxt;
            Mode_Change <= (mode_nxt != Mode_Index);
        end
    end

endmodule
